alu_arbiter: RTL and testbench

- Shares the single combinational 64-bit ALU between two requesters: req0 (main execute path) and req1 (branch/address unit).
- Round-robin grant with valid/ready handshakes on both the request and response sides.
- Operands are registered into an issue stage and driven onto the shared ALU. Result and flags are captured into a per-requester response register.
- Sits between the decode/issue logic and the ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 40 ++++
 rtl/alu_arbiter_rsp_slot.sv | 33 +++
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, flag
// indices, FSM states and the packed response record.
package alu_arbiter_pkg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 4;
  localparam int FLAG_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_EOR = 4'b0111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  typedef struct packed {
    logic              error;
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] result;
  } rsp_t;

  function automatic logic is_legal_ctrl(input logic [CTRL_W-1:0] ctrl);
    logic w_ok;
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_EOR: w_ok = 1'b1;
      default:                                    w_ok = 1'b0;
    endcase
    return w_ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_rsp_slot.sv
// One per-requester response register: loads on capture, holds until drained.
// Latency: visible the cycle after capture; backpressure: holds while i_rdy=0.
module alu_arbiter_rsp_slot
  import alu_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_cap,
  input  rsp_t i_rsp,
  input  logic i_rdy,
  output logic o_vld,
  output rsp_t o_rsp
);

  logic r_vld;
  rsp_t r_rsp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_rsp <= '0;
    end else if (i_cap) begin
      r_vld <= 1'b1;
      r_rsp <= i_rsp;
    end else if (r_vld && i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_rsp = r_rsp;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Latency: accept-to-rspValid 2 cycles, 1 op per 2 cycles; a pending response blocks its requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            reqValid,
  output logic [1:0]            reqReady,
  input  logic [CTRL_WIDTH-1:0] reqControl0,
  input  logic [DATA_WIDTH-1:0] reqOpA0,
  input  logic [DATA_WIDTH-1:0] reqOpB0,
  input  logic [CTRL_WIDTH-1:0] reqControl1,
  input  logic [DATA_WIDTH-1:0] reqOpA1,
  input  logic [DATA_WIDTH-1:0] reqOpB1,
  output logic [1:0]            rspValid,
  input  logic [1:0]            rspReady,
  output logic [DATA_WIDTH-1:0] rspResult0,
  output logic [DATA_WIDTH-1:0] rspResult1,
  output logic [3:0]            rspFlags0,
  output logic [3:0]            rspFlags1,
  output logic [1:0]            rspError,
  output logic [CTRL_WIDTH-1:0] aluControl,
  output logic [DATA_WIDTH-1:0] aluOperandA,
  output logic [DATA_WIDTH-1:0] aluOperandB,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic                  aluZero,
  input  logic                  aluCarry,
  input  logic                  aluNegative,
  input  logic                  aluOverflow
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  r_rr_ptr;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic                  r_illegal;

  logic [1:0]            w_elig;
  logic [1:0]            w_grant;
  logic                  w_grant_idx;
  logic                  w_accept;
  logic [1:0]            w_cap;
  rsp_t                  w_cap_rsp;
  logic                  w_vld0;
  logic                  w_vld1;
  rsp_t                  w_rsp0;
  rsp_t                  w_rsp1;
  logic [CTRL_WIDTH-1:0] w_sel_ctrl;

  // Eligibility looks at the registered response valids, so a slot being
  // drained this cycle still blocks its requester until the next one.
  always_comb begin
    w_elig  = reqValid & ~rspValid;
    w_grant = 2'b00;
    case (w_elig)
      2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      default: w_grant = 2'b00;
    endcase
    w_grant_idx = w_grant[1];
    w_sel_ctrl  = w_grant_idx ? reqControl1 : reqControl0;
  end

  always_comb begin
    w_state_nxt = r_state;
    reqReady    = 2'b00;
    w_accept    = 1'b0;
    w_cap       = 2'b00;
    aluControl  = '0;
    aluOperandA = '0;
    aluOperandB = '0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          reqReady = w_grant;
          w_accept = |w_grant;
        end
        if (w_accept) w_state_nxt = EXEC;
      end
      EXEC: begin
        w_cap[r_owner] = 1'b1;
        if (!r_illegal) begin
          aluControl  = r_ctrl;
          aluOperandA = r_op_a;
          aluOperandB = r_op_b;
        end
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner   <= 1'b0;
      r_rr_ptr  <= 1'b0;
      r_ctrl    <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_owner   <= w_grant_idx;
      r_rr_ptr  <= ~w_grant_idx;
      r_ctrl    <= w_sel_ctrl;
      r_op_a    <= w_grant_idx ? reqOpA1 : reqOpA0;
      r_op_b    <= w_grant_idx ? reqOpB1 : reqOpB0;
      r_illegal <= !is_legal_ctrl(w_sel_ctrl);
    end
  end

  // An illegal op never reaches the ALU, so its response is forced to zero.
  always_comb begin
    w_cap_rsp        = '0;
    w_cap_rsp.error  = r_illegal;
    if (!r_illegal) begin
      w_cap_rsp.result         = aluResult;
      w_cap_rsp.flags[FLAG_Z]  = aluZero;
      w_cap_rsp.flags[FLAG_C]  = aluCarry;
      w_cap_rsp.flags[FLAG_N]  = aluNegative;
      w_cap_rsp.flags[FLAG_V]  = aluOverflow;
    end
  end

  alu_arbiter_rsp_slot u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_cap (w_cap[0]),
    .i_rsp (w_cap_rsp),
    .i_rdy (rspReady[0]),
    .o_vld (w_vld0),
    .o_rsp (w_rsp0)
  );

  alu_arbiter_rsp_slot u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_cap (w_cap[1]),
    .i_rsp (w_cap_rsp),
    .i_rdy (rspReady[1]),
    .o_vld (w_vld1),
    .o_rsp (w_rsp1)
  );

  assign rspValid   = {w_vld1, w_vld0};
  assign rspError   = {w_rsp1.error, w_rsp0.error};
  assign rspResult0 = w_rsp0.result;
  assign rspResult1 = w_rsp1.result;
  assign rspFlags0  = w_rsp0.flags;
  assign rspFlags1  = w_rsp1.flags;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port, transaction-level
// reference of the arbiter compared every cycle, plus pinned literal cases.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [3:0]  reqControl0, reqControl1;
  logic [63:0] reqOpA0, reqOpB0, reqOpA1, reqOpB1;
  logic [1:0]  rspValid;
  logic [1:0]  rspReady;
  logic [63:0] rspResult0, rspResult1;
  logic [3:0]  rspFlags0, rspFlags1;
  logic [1:0]  rspError;
  logic [3:0]  aluControl;
  logic [63:0] aluOperandA, aluOperandB;
  logic [63:0] aluResult;
  logic        aluZero, aluCarry, aluNegative, aluOverflow;

  int cmp_n  = 0;
  int fail_n = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(64), .CTRL_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqControl0(reqControl0), .reqOpA0(reqOpA0), .reqOpB0(reqOpB0),
    .reqControl1(reqControl1), .reqOpA1(reqOpA1), .reqOpB1(reqOpB1),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspResult0(rspResult0), .rspResult1(rspResult1),
    .rspFlags0(rspFlags0), .rspFlags1(rspFlags1), .rspError(rspError),
    .aluControl(aluControl), .aluOperandA(aluOperandA), .aluOperandB(aluOperandB),
    .aluResult(aluResult), .aluZero(aluZero), .aluCarry(aluCarry),
    .aluNegative(aluNegative), .aluOverflow(aluOverflow)
  );

  // Returns {V,N,C,Z,result}; carry on SUB is bit 64 of the 65-bit difference.
  function automatic logic [67:0] alu_ref(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] w;
    logic [63:0] r;
    logic        cy, v;
    w = '0; r = '0; cy = 1'b0; v = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        w = {1'b0, a} + {1'b0, b}; r = w[63:0]; cy = w[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      4'b0110: begin
        w = {1'b0, a} - {1'b0, b}; r = w[63:0]; cy = w[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      4'b0111: r = a ^ b;
      default: r = '0;
    endcase
    return {v, r[63], cy, (r == 64'd0), r};
  endfunction

  function automatic logic legal(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd6) || (c == 4'd7);
  endfunction

  logic [67:0] alu_out;
  always_comb alu_out = alu_ref(aluControl, aluOperandA, aluOperandB);
  assign aluResult   = alu_out[63:0];
  assign aluZero     = alu_out[64];
  assign aluCarry    = alu_out[65];
  assign aluNegative = alu_out[66];
  assign aluOverflow = alu_out[67];

  // Reference state: one op in flight or none, a preferred requester, two slots.
  logic        m_busy, m_own, m_rr;
  logic [3:0]  m_ctrl;
  logic [63:0] m_a, m_b;
  logic [1:0]  m_vld, m_err;
  logic [63:0] m_res [2];
  logic [3:0]  m_flg [2];

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_rr = 0; m_ctrl = 0; m_a = 0; m_b = 0;
    m_vld = 0; m_err = 0;
    for (int i = 0; i < 2; i++) begin m_res[i] = 0; m_flg[i] = 0; end
  endtask

  function automatic logic [1:0] exp_grant();
    logic [1:0] e;
    e = reqValid & ~m_vld;
    if (e == 2'b11) return m_rr ? 2'b10 : 2'b01;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already applied: compare, advance model, next falling edge.
  task automatic tick();
    logic [1:0]  g;
    logic        go;
    logic [67:0] r;
    #1;
    g  = (rst_n && !m_busy) ? exp_grant() : 2'b00;
    go = m_busy && legal(m_ctrl);
    chk("reqReady", {62'd0, reqReady}, {62'd0, g});
    chk("aluControl", {60'd0, aluControl}, go ? {60'd0, m_ctrl} : 64'd0);
    chk("aluOperandA", aluOperandA, go ? m_a : 64'd0);
    chk("aluOperandB", aluOperandB, go ? m_b : 64'd0);
    chk("rspValid", {62'd0, rspValid}, {62'd0, m_vld});
    chk("rspError", {62'd0, rspError}, {62'd0, m_err});
    chk("rspResult0", rspResult0, m_res[0]);
    chk("rspResult1", rspResult1, m_res[1]);
    chk("rspFlags0", {60'd0, rspFlags0}, {60'd0, m_flg[0]});
    chk("rspFlags1", {60'd0, rspFlags1}, {60'd0, m_flg[1]});
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) if (m_vld[i] && rspReady[i]) m_vld[i] = 1'b0;
      if (m_busy) begin
        r = legal(m_ctrl) ? alu_ref(m_ctrl, m_a, m_b) : 68'd0;
        m_vld[m_own] = 1'b1;
        m_res[m_own] = r[63:0];
        m_flg[m_own] = r[67:64];
        m_err[m_own] = !legal(m_ctrl);
        m_busy = 1'b0;
      end else if (g != 2'b00) begin
        m_busy = 1'b1;
        m_own  = g[1];
        m_rr   = ~g[1];
        m_ctrl = g[1] ? reqControl1 : reqControl0;
        m_a    = g[1] ? reqOpA1 : reqOpA0;
        m_b    = g[1] ? reqOpB1 : reqOpB0;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int idx, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    if (idx == 0) begin reqControl0 = c; reqOpA0 = a; reqOpB0 = b; end
    else          begin reqControl1 = c; reqOpA1 = a; reqOpB1 = b; end
  endtask

  function automatic logic [3:0] rand_ctrl();
    logic [3:0] tbl [5];
    tbl[0] = 4'd0; tbl[1] = 4'd1; tbl[2] = 4'd2; tbl[3] = 4'd6; tbl[4] = 4'd7;
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return tbl[$urandom_range(0, 4)];
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return {1'b0, {63{1'b1}}};
      3:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int g0, g1;
    int gq [$];
    rst_n = 1'b0; reqValid = 2'b00; rspReady = 2'b00;
    set_req(0, 4'd0, 64'd0, 64'd0);
    set_req(1, 4'd0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // Single ADD on requester 0
    rspReady = 2'b11;
    set_req(0, 4'b0010, 64'd5, 64'd7);
    reqValid = 2'b01;
    #1 chk("s1_rdy", {62'd0, reqReady}, 64'd1);
    tick();
    reqValid = 2'b00;
    tick();
    #1 chk("s1_vld", {62'd0, rspValid}, 64'd1);
    chk("s1_res", rspResult0, 64'd12);
    chk("s1_flg", {60'd0, rspFlags0}, 64'd0);
    tick();
    #1 chk("s1_clr", {62'd0, rspValid}, 64'd0);
    tick();

    // Illegal control code on requester 1
    set_req(1, 4'b1111, 64'h1234, 64'h5678);
    reqValid = 2'b10;
    tick();
    reqValid = 2'b00;
    #1 chk("s4_ctl", {60'd0, aluControl}, 64'd0);
    chk("s4_opa", aluOperandA, 64'd0);
    chk("s4_opb", aluOperandB, 64'd0);
    tick();
    #1 chk("s4_err", {62'd0, rspError}, 64'd2);
    chk("s4_res", rspResult1, 64'd0);
    chk("s4_flg", {60'd0, rspFlags1}, 64'd0);
    tick(); tick();

    // Signed overflow on ADD
    set_req(0, 4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    reqValid = 2'b01;
    tick();
    reqValid = 2'b00;
    tick();
    #1 chk("s5_res", rspResult0, 64'h8000_0000_0000_0000);
    chk("s5_flg", {60'd0, rspFlags0}, 64'hC);
    tick(); tick();

    // Reset during the EXEC cycle discards the op
    set_req(1, 4'b0010, 64'd3, 64'd4);
    reqValid = 2'b10;
    tick();
    reqValid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 chk("rst_vld", {62'd0, rspValid}, 64'd0);
    chk("rst_ctl", {60'd0, aluControl}, 64'd0);
    tick();

    // Both requesting every cycle: grants alternate starting at 0
    reqValid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      set_req(0, rand_ctrl(), rand_op(), rand_op());
      set_req(1, rand_ctrl(), rand_op(), rand_op());
      #1 if (reqReady != 2'b00) gq.push_back(reqReady[1] ? 1 : 0);
      tick();
    end
    chk("s2_n", 64'(gq.size()), 64'd4);
    for (int k = 0; k < 4 && k < gq.size(); k++) chk("s2_grant", 64'(gq[k]), 64'(k % 2));
    reqValid = 2'b00;
    repeat (3) tick();

    // Stalled SUB response on requester 0 while requester 1 keeps going
    set_req(0, 4'b0110, 64'd0, 64'd1);
    rspReady = 2'b10;
    reqValid = 2'b11;
    g0 = 0; g1 = 0;
    for (int k = 0; k < 10; k++) begin
      set_req(1, rand_ctrl(), rand_op(), rand_op());
      #1 if (reqReady[0]) g0++;
      if (reqReady[1]) g1++;
      tick();
    end
    chk("s3_g0", 64'(g0), 64'd1);
    chk("s3_g1", {63'd0, g1 >= 3}, 64'd1);
    chk("s3_vld0", {63'd0, rspValid[0]}, 64'd1);
    chk("s3_res", rspResult0, {64{1'b1}});
    chk("s3_flg", {60'd0, rspFlags0}, 64'h6);
    reqValid = 2'b00;
    rspReady = 2'b11;
    repeat (3) tick();

    // Randomized traffic against the reference
    for (int k = 0; k < 800; k++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      reqValid = 2'($urandom);
      rspReady = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 5) == 0) rspReady = 2'b00;
      set_req(0, rand_ctrl(), rand_op(), rand_op());
      set_req(1, rand_ctrl(), rand_op(), rand_op());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
